// File: rtl/mem_stage_lsu_if.sv
// Data bus between the MEM stage LSU and the memory subsystem.
// master = LSU side (drives request fields), slave = memory side (drives grant/response).
// Request fields stay stable from mem_req rise until mem_gnt; mem_rvalid returns read data.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: registers EX results into the MEM/WB slot and runs loads/stores on the data bus.
// Latency: ALU ops 1 cycle; stores 1 cycle after mem_gnt; loads 1 cycle after mem_rvalid (or timeout).
// Backpressure: ex_ready only in IDLE with a free/draining WB slot; the slot holds until wb_ready.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned half/word accesses fault instead of using the bus).
module mem_stage_lsu #(
  parameter int ADDR_W  = 32,
  parameter int RESP_TO = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [31:0]          ex_alu_result,
  input  logic [31:0]          ex_store_data,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_reg_wen,
  input  logic                 ex_mem_wen,
  input  logic                 ex_mem_ren,
  input  logic [2:0]           ex_mem_type,
  input  logic                 ex_mem_unsigned,
  input  logic [1:0]           ex_wb_sel,
  mem_stage_lsu_if.master      mem,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [4:0]           wb_rd,
  output logic                 wb_reg_wen,
  output logic [1:0]           wb_sel,
  output logic [31:0]          wb_alu_result,
  output logic [31:0]          wb_load_data,
  output logic                 bus_timeout
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                 misalign_fault,
  output logic [31:0]          misalign_addr
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              xfer, is_mem, is_store, misalign;
  logic              complete, rsp_hit, to_hit;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_store, acc_unsigned;
  logic [2:0]        acc_type;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wstrb;
  logic [31:0]       to_cnt;
  logic [31:0]       st_wdata, load_ext;
  logic [3:0]        st_wstrb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign ex_ready = (state == IDLE) && (!wb_valid || wb_ready);
  assign xfer     = ex_valid && ex_ready;
  assign is_mem   = ex_mem_wen || ex_mem_ren;
  // A store flag wins when both enables are set.
  assign is_store = ex_mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
  // Half needs addr[0]==0; word (including unused type codes) needs addr[1:0]==0.
  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      if (ex_mem_type == 3'b001)
        misalign = ex_alu_result[0];
      else if (ex_mem_type != 3'b000)
        misalign = (ex_alu_result[1:0] != 2'b00);
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Request fields are held in registers so they stay stable while waiting for grant.
  assign mem.mem_req   = (state == REQ);
  assign mem.mem_we    = acc_store;
  assign mem.mem_addr  = {acc_addr[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = acc_wdata;
  assign mem.mem_wstrb = acc_wstrb;

  // Store lane placement from the EX-side address offset.
  always_comb begin
    st_wstrb = 4'hF;
    st_wdata = ex_store_data;
    case (ex_mem_type)
      3'b000: begin
        st_wstrb = 4'b0001 << ex_alu_result[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      3'b001: begin
        st_wstrb = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension using the latched access attributes.
  always_comb begin
    ld_byte  = mem.mem_rdata[{acc_addr[1:0], 3'b000} +: 8];
    ld_half  = mem.mem_rdata[{acc_addr[1], 4'b0000} +: 16];
    load_ext = mem.mem_rdata;
    case (acc_type)
      3'b000:  load_ext = {{24{~acc_unsigned & ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{~acc_unsigned & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state and completion strobes.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    rsp_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && is_mem) state_nxt = misalign ? DONE : REQ;
      end
      REQ: begin
        if (mem.mem_gnt) begin
          if (acc_store) begin
            state_nxt = DONE;
            complete  = 1'b1;
          end else if (mem.mem_rvalid) begin
            state_nxt = DONE;
            rsp_hit   = 1'b1;
            complete  = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_nxt = DONE;
          rsp_hit   = 1'b1;
          complete  = 1'b1;
        end else if (RESP_TO != 0 && to_cnt == 32'(RESP_TO - 1)) begin
          state_nxt = DONE;
          to_hit    = 1'b1;
          complete  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MEM/WB slot, access latch and response-timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_wen    <= 1'b0;
      wb_sel        <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      bus_timeout   <= 1'b0;
      acc_addr      <= '0;
      acc_store     <= 1'b0;
      acc_unsigned  <= 1'b0;
      acc_type      <= '0;
      acc_wdata     <= '0;
      acc_wstrb     <= '0;
      to_cnt        <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_fault <= 1'b0;
      misalign_addr  <= '0;
`endif
    end else begin
      bus_timeout <= to_hit;
      to_cnt      <= (state == WAIT) ? to_cnt + 32'd1 : 32'd0;

      if ((xfer && (!is_mem || misalign)) || complete)
        wb_valid <= 1'b1;
      else if (wb_ready)
        wb_valid <= 1'b0;

      if (xfer) begin
        wb_rd         <= ex_rd;
        wb_reg_wen    <= ex_reg_wen & ~misalign;
        wb_sel        <= ex_wb_sel;
        wb_alu_result <= ex_alu_result;
        wb_load_data  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_fault <= misalign;
        misalign_addr  <= ex_alu_result;
`endif
      end else if (rsp_hit) begin
        wb_load_data <= load_ext;
      end

      if (xfer && is_mem && !misalign) begin
        acc_addr     <= ex_alu_result[ADDR_W-1:0];
        acc_store    <= is_store;
        acc_unsigned <= ex_mem_unsigned;
        acc_type     <= ex_mem_type;
        acc_wdata    <= is_store ? st_wdata : 32'd0;
        acc_wstrb    <= is_store ? st_wstrb : 4'd0;
      end
    end
  end

endmodule
